// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity encodings, receiver
// state encoding and the small sizing helpers used by the receiver and its FIFO.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK
    } rx_state_t;

    // System clocks per oversampling tick.
    function automatic int calc_tdiv(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

    // Width of a counter that must hold the values 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO buffering received words ahead of the AXI-Stream output.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [WIDTH-1:0]              wdata,
    input  logic                          pop,
    output logic [WIDTH-1:0]              rdata,
    output logic                          full,
    output logic                          empty,
    output logic [level_width(DEPTH)-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_LVL);
    assign empty   = (count == '0);
    assign level   = count;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head is masked while empty so tdata reads 0 out of reset.
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: the storage array has no reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_rx_axis.sv
// UART receiver with 16x oversampling, 3-sample majority vote, error detection
// and an AXI-Stream master output fed from an internal FIFO.
module uart_rx_axis
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               rx,
    output logic [DATA_BITS-1:0]               m_axis_tdata,
    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready,
    output logic                               parity_err,
    output logic                               frame_err,
    output logic                               break_det,
    output logic                               overrun,
    output logic [level_width(FIFO_DEPTH)-1:0] fifo_level
);
    localparam int TDIV = calc_tdiv(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int DW   = $clog2(TDIV);
    localparam int TW   = $clog2(OVERSAMPLE);
    localparam int BW   = $clog2(DATA_BITS);

    localparam logic [DW-1:0] LAST_DIV  = DW'(TDIV - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] K0        = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] K1        = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] K2        = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = (STOP_BITS == 2);

    rx_state_t state_q, state_d;

    logic rx_meta, rx_sync, rx_prev, fall;
    logic [DW-1:0] div_cnt;
    logic [TW-1:0] tick_cnt;
    logic tick, bit_done, s0, s1, bit_val;

    logic [DATA_BITS-1:0] data_q;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic                 par_q, any_one, stop_zero;
    logic                 par_bad, brk_frame;

    logic push, par_d, frm_d, brk_d, ovr_d;
    logic fifo_full, fifo_empty, pop;

    // NOTE: synchroniser flops reset to the idle level so release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall     = rx_prev && !rx_sync;
    assign tick     = (div_cnt == LAST_DIV);
    assign bit_done = tick && (tick_cnt == K2);
    assign bit_val  = (s0 & s1) | (s0 & rx_sync) | (s1 & rx_sync);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
            s0       <= 1'b1;
            s1       <= 1'b1;
        end else begin
            if (state_q == ST_IDLE && fall) begin
                div_cnt  <= '0;
                tick_cnt <= '0;
            end else if (tick) begin
                div_cnt  <= '0;
                tick_cnt <= (tick_cnt == LAST_TICK) ? '0 : tick_cnt + 1'b1;
            end else begin
                div_cnt  <= div_cnt + 1'b1;
            end
            if (tick && tick_cnt == K0) s0 <= rx_sync;
            if (tick && tick_cnt == K1) s1 <= rx_sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        par_d     = 1'b0;
        frm_d     = 1'b0;
        brk_d     = 1'b0;
        ovr_d     = 1'b0;
        par_bad   = (PARITY == PAR_ODD) ? !(^data_q ^ par_q) : (^data_q ^ par_q);
        brk_frame = !(any_one || bit_val);
        case (state_q)
            ST_IDLE:   if (fall) state_d = ST_START;
            ST_START:  if (bit_done) state_d = bit_val ? ST_IDLE : ST_DATA;
            ST_DATA:   if (bit_done && bit_idx == LAST_BIT)
                           state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_done) state_d = ST_STOP;
            ST_STOP: begin
                // Resolve at the mid-sample of the last stop bit; the tail is not waited out.
                if (bit_done && stop_idx == LAST_STOP) begin
                    if (brk_frame) begin
                        brk_d   = 1'b1;
                        state_d = ST_BRK;
                    end else begin
                        state_d = ST_IDLE;
                        if (stop_zero || !bit_val)                 frm_d = 1'b1;
                        else if (PARITY != PAR_NONE && par_bad)    par_d = 1'b1;
                        else if (fifo_full && !pop)                ovr_d = 1'b1;
                        else                                       push  = 1'b1;
                    end
                end
            end
            ST_BRK:    if (rx_sync) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q     <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            par_q      <= 1'b0;
            any_one    <= 1'b0;
            stop_zero  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            parity_err <= par_d;
            frame_err  <= frm_d;
            break_det  <= brk_d;
            overrun    <= ovr_d;
            case (state_q)
                ST_START: begin
                    bit_idx   <= '0;
                    stop_idx  <= 1'b0;
                    par_q     <= 1'b0;
                    any_one   <= 1'b0;
                    stop_zero <= 1'b0;
                end
                ST_DATA: if (bit_done) begin
                    data_q  <= {bit_val, data_q[DATA_BITS-1:1]};
                    bit_idx <= bit_idx + 1'b1;
                    any_one <= any_one | bit_val;
                end
                ST_PARITY: if (bit_done) begin
                    par_q   <= bit_val;
                    any_one <= any_one | bit_val;
                end
                ST_STOP: if (bit_done) begin
                    stop_idx  <= stop_idx + 1'b1;
                    any_one   <= any_one | bit_val;
                    stop_zero <= stop_zero | !bit_val;
                end
                default: ;
            endcase
        end
    end

    assign pop           = m_axis_tvalid && m_axis_tready;
    assign m_axis_tvalid = !fifo_empty;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (data_q),
        .pop   (pop),
        .rdata (m_axis_tdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

endmodule

// File: tb/tb_uart_rx_axis.sv
// Directed bench for uart_rx_axis: an 8E1 instance and a 7N2 instance, one bit
// time is 160 clocks (TDIV = 10, 16 ticks per bit).
module tb_uart_rx_axis;
    localparam int BIT_CLKS = 160;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_a = 1'b1, tready_a = 1'b0;
    logic rx_b = 1'b1, tready_b = 1'b0;

    logic [7:0] tdata_a;
    logic       tvalid_a, par_a, frm_a, brk_a, ovr_a;
    logic [3:0] lvl_a;
    logic [6:0] tdata_b;
    logic       tvalid_b, par_b, frm_b, brk_b, ovr_b;
    logic [3:0] lvl_b;

    int total = 0;
    int bad = 0;
    int n_par_a = 0, n_frm_a = 0, n_brk_a = 0, n_ovr_a = 0, n_valid_a = 0;
    int n_par_b = 0, n_frm_b = 0, n_brk_b = 0, n_ovr_b = 0;
    logic [7:0] beats_a[$];
    logic [6:0] beats_b[$];

    always #5 clk = ~clk;

    uart_rx_axis #(
        .CLK_FREQ(18_432_000), .BAUD(115200), .DATA_BITS(8), .PARITY(1),
        .STOP_BITS(1), .OVERSAMPLE(16), .FIFO_DEPTH(8)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .rx(rx_a),
        .m_axis_tdata(tdata_a), .m_axis_tvalid(tvalid_a), .m_axis_tready(tready_a),
        .parity_err(par_a), .frame_err(frm_a), .break_det(brk_a), .overrun(ovr_a),
        .fifo_level(lvl_a)
    );

    uart_rx_axis #(
        .CLK_FREQ(18_432_000), .BAUD(115200), .DATA_BITS(7), .PARITY(0),
        .STOP_BITS(2), .OVERSAMPLE(16), .FIFO_DEPTH(8)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .rx(rx_b),
        .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b), .m_axis_tready(tready_b),
        .parity_err(par_b), .frame_err(frm_b), .break_det(brk_b), .overrun(ovr_b),
        .fifo_level(lvl_b)
    );

    // Outputs are observed on the falling edge, half a cycle away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tvalid_a && tready_a) beats_a.push_back(tdata_a);
            if (tvalid_a) n_valid_a++;
            if (par_a) n_par_a++;
            if (frm_a) n_frm_a++;
            if (brk_a) n_brk_a++;
            if (ovr_a) n_ovr_a++;
            if (tvalid_b && tready_b) beats_b.push_back(tdata_b);
            if (par_b) n_par_b++;
            if (frm_b) n_frm_b++;
            if (brk_b) n_brk_b++;
            if (ovr_b) n_ovr_b++;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
    endtask

    task automatic send_frame(input bit sel, input logic [8:0] data, input int nbits,
                              input bit has_par, input logic par,
                              input int nstop, input logic [1:0] stops);
        drive(sel, 1'b0);
        wait_clks(BIT_CLKS);
        for (int i = 0; i < nbits; i++) begin
            drive(sel, data[i]);
            wait_clks(BIT_CLKS);
        end
        if (has_par) begin
            drive(sel, par);
            wait_clks(BIT_CLKS);
        end
        for (int i = 0; i < nstop; i++) begin
            drive(sel, stops[i]);
            wait_clks(BIT_CLKS);
        end
        drive(sel, 1'b1);
        wait_clks(BIT_CLKS / 2);
    endtask

    // 8 data bits, the given parity bit, one stop bit on instance A.
    task automatic send_a(input logic [7:0] d, input logic p, input logic stop);
        send_frame(1'b0, {1'b0, d}, 8, 1'b1, p, 1, {1'b1, stop});
    endtask

    function automatic int errs_a();
        return n_par_a + n_frm_a + n_brk_a + n_ovr_a;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        wait_clks(3);
        total++;
        if ({tvalid_a, par_a, frm_a, brk_a, ovr_a, lvl_a, tdata_a} !== 17'd0) begin
            bad++;
            $display("FAIL reset_a_outputs: got %h want 0",
                     {tvalid_a, par_a, frm_a, brk_a, ovr_a, lvl_a, tdata_a});
        end
        total++;
        if ({tvalid_b, par_b, frm_b, brk_b, ovr_b, lvl_b, tdata_b} !== 16'd0) begin
            bad++;
            $display("FAIL reset_b_outputs: got %h want 0",
                     {tvalid_b, par_b, frm_b, brk_b, ovr_b, lvl_b, tdata_b});
        end
        rst_n = 1'b1;
        wait_clks(20);
        total++;
        if ({tvalid_a, lvl_a, tvalid_b, lvl_b} !== 10'd0) begin
            bad++;
            $display("FAIL post_reset_idle: got %h want 0", {tvalid_a, lvl_a, tvalid_b, lvl_b});
        end
    endtask

    task automatic test_good_frame();
        int base = beats_a.size();
        int e0 = errs_a();
        tready_a = 1'b1;
        send_a(8'hA5, 1'b0, 1'b1);
        wait_clks(20);
        total++;
        if (beats_a.size() != base + 1) begin
            bad++;
            $display("FAIL good_beat_count: got %0d want %0d", beats_a.size(), base + 1);
        end else begin
            total++;
            if (beats_a[base] !== 8'hA5) begin
                bad++;
                $display("FAIL good_tdata: got %h want a5", beats_a[base]);
            end
        end
        total++;
        if (errs_a() != e0) begin
            bad++;
            $display("FAIL good_no_errors: got %0d want %0d", errs_a(), e0);
        end
        total++;
        if (lvl_a !== 4'd0) begin
            bad++;
            $display("FAIL good_level: got %0d want 0", lvl_a);
        end
    endtask

    task automatic test_parity();
        int base = beats_a.size();
        int v0 = n_valid_a;
        int p0 = n_par_a;
        send_a(8'h3C, 1'b1, 1'b1);
        wait_clks(20);
        total++;
        if (n_par_a != p0 + 1) begin
            bad++;
            $display("FAIL parity_pulse: got %0d want %0d", n_par_a - p0, 1);
        end
        total++;
        if (n_valid_a != v0 || beats_a.size() != base) begin
            bad++;
            $display("FAIL parity_no_push: got valid_cycles=%0d want 0", n_valid_a - v0);
        end
    endtask

    task automatic test_framing();
        int base = beats_a.size();
        int f0 = n_frm_a;
        int p0 = n_par_a;
        send_a(8'h55, 1'b0, 1'b0);
        wait_clks(20);
        total++;
        if (n_frm_a != f0 + 1) begin
            bad++;
            $display("FAIL frame_pulse: got %0d want 1", n_frm_a - f0);
        end
        total++;
        if (beats_a.size() != base || n_par_a != p0) begin
            bad++;
            $display("FAIL frame_no_push: got beats=%0d par=%0d want 0 0",
                     beats_a.size() - base, n_par_a - p0);
        end
    endtask

    task automatic test_break();
        int base = beats_a.size();
        int b0 = n_brk_a;
        int f0 = n_frm_a;
        rx_a = 1'b0;
        wait_clks(12 * BIT_CLKS);
        rx_a = 1'b1;
        wait_clks(2 * BIT_CLKS);
        total++;
        if (n_brk_a != b0 + 1 || n_frm_a != f0) begin
            bad++;
            $display("FAIL break_pulse: got brk=%0d frm=%0d want 1 0", n_brk_a - b0, n_frm_a - f0);
        end
        send_a(8'h12, 1'b0, 1'b1);
        wait_clks(20);
        total++;
        if (beats_a.size() != base + 1) begin
            bad++;
            $display("FAIL break_recover_count: got %0d want 1", beats_a.size() - base);
        end else begin
            total++;
            if (beats_a[base] !== 8'h12) begin
                bad++;
                $display("FAIL break_recover_tdata: got %h want 12", beats_a[base]);
            end
        end
    endtask

    task automatic test_overrun();
        int base;
        int o0 = n_ovr_a;
        logic [7:0] d;
        tready_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            d = 8'(i);
            send_a(d, ^d, 1'b1);
        end
        total++;
        if (lvl_a !== 4'd8 || n_ovr_a != o0) begin
            bad++;
            $display("FAIL fill_level: got level=%0d ovr=%0d want 8 0", lvl_a, n_ovr_a - o0);
        end
        total++;
        if (tdata_a !== 8'h00 || tvalid_a !== 1'b1) begin
            bad++;
            $display("FAIL stall_head: got tdata=%h tvalid=%b want 00 1", tdata_a, tvalid_a);
        end
        send_a(8'h08, 1'b1, 1'b1);
        wait_clks(10);
        total++;
        if (n_ovr_a != o0 + 1 || lvl_a !== 4'd8) begin
            bad++;
            $display("FAIL overrun_pulse: got ovr=%0d level=%0d want 1 8", n_ovr_a - o0, lvl_a);
        end
        base = beats_a.size();
        tready_a = 1'b1;
        wait_clks(20);
        total++;
        if (beats_a.size() != base + 8 || lvl_a !== 4'd0) begin
            bad++;
            $display("FAIL drain_count: got beats=%0d level=%0d want 8 0", beats_a.size() - base, lvl_a);
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (beats_a[base + i] !== 8'(i)) begin
                    bad++;
                    $display("FAIL drain_order[%0d]: got %h want %h", i, beats_a[base + i], 8'(i));
                end
            end
        end
    endtask

    task automatic test_glitch_and_reset();
        int base = beats_a.size();
        int e0 = errs_a();
        int v0 = n_valid_a;
        rx_a = 1'b0;
        wait_clks(40);
        rx_a = 1'b1;
        wait_clks(3 * BIT_CLKS);
        total++;
        if (errs_a() != e0 || n_valid_a != v0 || beats_a.size() != base) begin
            bad++;
            $display("FAIL glitch_quiet: got errs=%0d valid=%0d want 0 0", errs_a() - e0, n_valid_a - v0);
        end
        tready_a = 1'b0;
        send_a(8'h33, 1'b0, 1'b1);
        wait_clks(5);
        total++;
        if (lvl_a !== 4'd1) begin
            bad++;
            $display("FAIL pre_reset_level: got %0d want 1", lvl_a);
        end
        rx_a = 1'b0;
        wait_clks(BIT_CLKS);
        rx_a = 1'b1;
        wait_clks(2 * BIT_CLKS);
        rst_n = 1'b0;
        wait_clks(2);
        total++;
        if ({tvalid_a, par_a, frm_a, brk_a, ovr_a, lvl_a, tdata_a} !== 17'd0) begin
            bad++;
            $display("FAIL midframe_reset: got %h want 0",
                     {tvalid_a, par_a, frm_a, brk_a, ovr_a, lvl_a, tdata_a});
        end
        wait_clks(BIT_CLKS);
        rst_n = 1'b1;
        wait_clks(20);
        base = beats_a.size();
        e0 = errs_a();
        tready_a = 1'b1;
        send_a(8'h7E, 1'b0, 1'b1);
        wait_clks(20);
        total++;
        if (beats_a.size() != base + 1 || errs_a() != e0) begin
            bad++;
            $display("FAIL after_reset_count: got beats=%0d errs=%0d want 1 0",
                     beats_a.size() - base, errs_a() - e0);
        end else begin
            total++;
            if (beats_a[base] !== 8'h7E) begin
                bad++;
                $display("FAIL after_reset_tdata: got %h want 7e", beats_a[base]);
            end
        end
    endtask

    task automatic test_7n2();
        int base = beats_b.size();
        int f0 = n_frm_b;
        int e0 = n_par_b + n_brk_b + n_ovr_b;
        tready_b = 1'b1;
        send_frame(1'b1, 9'h055, 7, 1'b0, 1'b0, 2, 2'b11);
        wait_clks(20);
        total++;
        if (beats_b.size() != base + 1 || n_frm_b != f0) begin
            bad++;
            $display("FAIL b_good_count: got beats=%0d frm=%0d want 1 0", beats_b.size() - base, n_frm_b - f0);
        end else begin
            total++;
            if (beats_b[base] !== 7'h55) begin
                bad++;
                $display("FAIL b_good_tdata: got %h want 55", beats_b[base]);
            end
        end
        send_frame(1'b1, 9'h02A, 7, 1'b0, 1'b0, 2, 2'b01);
        wait_clks(20);
        total++;
        if (n_frm_b != f0 + 1 || beats_b.size() != base + 1) begin
            bad++;
            $display("FAIL b_second_stop: got frm=%0d beats=%0d want 1 1", n_frm_b - f0, beats_b.size() - base);
        end
        total++;
        if (n_par_b + n_brk_b + n_ovr_b != e0 || lvl_b !== 4'd0) begin
            bad++;
            $display("FAIL b_other_flags: got errs=%0d level=%0d want 0 0",
                     n_par_b + n_brk_b + n_ovr_b - e0, lvl_b);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity();
        test_framing();
        test_break();
        test_overrun();
        test_glitch_and_reset();
        test_7n2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
